regfile_sb: RTL



---
 rtl/npc_pkg.sv | 16 +
 rtl/sb_counter.sv | 41 ++++
 rtl/regfile_sb.sv | 103 ++++++++++
 3 files changed

// File: rtl/npc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : npc_pkg
//  Description : Shared register-file sizing constants and address type.
//  Revision    : 1.0 - initial release
// ============================================================================
package npc_pkg;
   localparam int XLEN   = 32;
   localparam int NREGS  = 32;
   localparam int REG_AW = 5;

   typedef logic [REG_AW-1:0] reg_addr_t;

   localparam reg_addr_t X0 = '0;
endpackage
`default_nettype wire

// File: rtl/sb_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sb_counter
//  Description : Saturating up/down pending-write counter with underflow pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module sb_counter #(
   parameter int CNT_W = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_inc,
   input  logic             i_dec,
   output logic [CNT_W-1:0] o_cnt,
   output logic             o_zero,
   output logic             o_max,
   output logic             o_unf
);
   localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

   logic [CNT_W-1:0] r_cnt;

   assign o_cnt  = r_cnt;
   assign o_zero = (r_cnt == '0);
   assign o_max  = (r_cnt == c_CNT_MAX);
   // A writeback with nothing pending is an error even if an issue lands alongside.
   assign o_unf  = i_dec && o_zero;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt <= '0;
      end else begin
         case ({i_inc, i_dec})
            2'b10:   if (!o_max)  r_cnt <= r_cnt + 1'b1;
            2'b01:   if (!o_zero) r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end
endmodule
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_sb
//  Description : Integer register file, two async read ports, pending-write
//                scoreboard. Optional write-through: REGFILE_WB_BYPASS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_sb
   import npc_pkg::*;
#(
   parameter int NREGS = npc_pkg::NREGS,
   parameter int XLEN  = npc_pkg::XLEN,
   parameter int CNT_W = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [XLEN-1:0]   wb_data,
   input  logic [REG_AW-1:0] wb_rd,
   input  logic              wb_reg_wen,
   input  logic [REG_AW-1:0] rs1_addr,
   input  logic [REG_AW-1:0] rs2_addr,
   output logic [XLEN-1:0]   rs1_data,
   output logic [XLEN-1:0]   rs2_data,
   output logic              rs1_busy,
   output logic              rs2_busy,
   input  logic              iss_valid,
   input  logic [REG_AW-1:0] iss_rd,
   input  logic              iss_wen,
   output logic              iss_ready,
   output logic              sb_err
);
   localparam int NSLOT = 1 << REG_AW;

   logic [XLEN-1:0]  r_regs [NSLOT];
   logic             r_sb_err;
   logic [CNT_W-1:0] w_cnt  [NSLOT];
   logic [NSLOT-1:0] w_zero;
   logic [NSLOT-1:0] w_max;
   logic [NSLOT-1:0] w_unf;
   logic             w_wb_q;
   logic             w_iss_inc;
   logic             w_hit1;
   logic             w_hit2;

   function automatic logic in_rf(input logic [REG_AW-1:0] a);
      return (a != X0) && (int'(a) < NREGS);
   endfunction

   assign w_wb_q    = wb_reg_wen && in_rf(wb_rd);
   assign w_iss_inc = iss_valid && iss_ready && iss_wen && in_rf(iss_rd);

   // Every address slot gets a counter view; x0 and out-of-range slots read as idle.
   generate
      for (genvar r = 0; r < NSLOT; r++) begin : g_slot
         if (r == 0 || r >= NREGS) begin : g_tie
            assign w_cnt[r]  = '0;
            assign w_zero[r] = 1'b1;
            assign w_max[r]  = 1'b0;
            assign w_unf[r]  = 1'b0;
         end else begin : g_cnt
            sb_counter #(.CNT_W(CNT_W)) u_cnt (
               .clk    (clk),
               .rst    (rst),
               .i_inc  (w_iss_inc && (iss_rd == REG_AW'(r))),
               .i_dec  (w_wb_q && (wb_rd == REG_AW'(r))),
               .o_cnt  (w_cnt[r]),
               .o_zero (w_zero[r]),
               .o_max  (w_max[r]),
               .o_unf  (w_unf[r])
            );
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NSLOT; i++) r_regs[i] <= '0;
         r_sb_err <= 1'b0;
      end else begin
         if (w_wb_q)  r_regs[wb_rd] <= wb_data;
         if (|w_unf)  r_sb_err      <= 1'b1;
      end
   end

`ifdef REGFILE_WB_BYPASS_EN
   assign w_hit1 = rst && w_wb_q && (wb_rd == rs1_addr);
   assign w_hit2 = rst && w_wb_q && (wb_rd == rs2_addr);
`else
   assign w_hit1 = 1'b0;
   assign w_hit2 = 1'b0;
`endif

   assign rs1_data = !in_rf(rs1_addr) ? '0 : (w_hit1 ? wb_data : r_regs[rs1_addr]);
   assign rs2_data = !in_rf(rs2_addr) ? '0 : (w_hit2 ? wb_data : r_regs[rs2_addr]);

   // On a same-cycle writeback hit, busy looks at the count after this write retires.
   assign rs1_busy = w_hit1 ? (w_cnt[rs1_addr] > CNT_W'(1)) : !w_zero[rs1_addr];
   assign rs2_busy = w_hit2 ? (w_cnt[rs2_addr] > CNT_W'(1)) : !w_zero[rs2_addr];

   assign iss_ready = !(iss_wen && w_max[iss_rd] && !(w_wb_q && (wb_rd == iss_rd)));
   assign sb_err    = r_sb_err;
endmodule
`default_nettype wire
